fb_wr_ctrl: RTL and testbench

//  Write-port controller for the dual-port frame-buffer RAM (ram_ip, port A). Shares the single

---
 rtl/fb_ctrl_pkg.sv | 14 +
 rtl/fb_wr_ctrl_arb2.sv | 45 ++++
 rtl/fb_wr_ctrl.sv | 114 +++++++++++
 tb/tb_fb_wr_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_ctrl_pkg.sv
// Shared types and default geometry for the frame-buffer write controller.
// The FB_RR_ARB_EN macro does not affect this package.
package fb_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int FB_ADDR_W = 20;
  localparam int FB_DATA_W = 1;
  localparam int FB_DEPTH  = 307200;

endpackage

// File: rtl/fb_wr_ctrl_arb2.sv
// Two-way write-port grant for the frame-buffer controller.
// FB_RR_ARB_EN selects round-robin; otherwise requester 0 has fixed priority.
module arb2
  import fb_ctrl_pkg::*;
(
`ifdef FB_RR_ARB_EN
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
`endif
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

`ifdef FB_RR_ARB_EN
  // ptr names the requester that wins a tie: 0 -> req0, 1 -> req1
  logic ptr;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (valid0 && valid1) begin
      gnt0 = !ptr;
      gnt1 = ptr;
    end else begin
      gnt0 = valid0;
      gnt1 = valid1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= gnt0;
    end
  end
`else
  assign gnt0 = valid0;
  assign gnt1 = valid1 && !valid0;
`endif

endmodule

// File: rtl/fb_wr_ctrl.sv
// Frame-buffer RAM port-A write controller: two requesters plus a clear sweep.
// Define FB_RR_ARB_EN for round-robin arbitration (default: req0 fixed priority).
module fb_wr_ctrl
  import fb_ctrl_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int DEPTH  = FB_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              wea,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              wr_drop
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              gnt0;
  logic              gnt1;
  logic              open;
  logic              xfer;
  logic              drop;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  arb2 u_arb (
`ifdef FB_RR_ARB_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (xfer),
`endif
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  // Requests are held off during the sweep and its completion cycle,
  // and a clear request in IDLE takes precedence over both requesters.
  assign open       = (state == IDLE) && !clr_start && !clr_done;
  assign req0_ready = open && gnt0;
  assign req1_ready = open && gnt1;
  assign xfer       = req0_ready || req1_ready;
  assign sel_addr   = req0_ready ? req0_addr : req1_addr;
  assign sel_data   = req0_ready ? req0_data : req1_data;
  assign drop       = sel_addr > LAST_ADDR;
  assign clr_busy   = (state == CLEAR);

  // ---- output register stage: RAM port A driven directly from here ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      wea      <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      wea      <= 1'b0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            wea     <= 1'b1;
            w_addr  <= '0;
            w_data  <= '0;
          end else if (xfer) begin
            if (drop) begin
              wr_drop <= 1'b1;
            end else begin
              wea    <= 1'b1;
              w_addr <= sel_addr;
              w_data <= sel_data;
            end
          end
        end
        CLEAR: begin
          // clr_cnt always equals the address currently presented on w_addr
          if (clr_cnt == LAST_ADDR) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
            wea     <= 1'b1;
            w_addr  <= clr_cnt + ADDR_W'(1);
            w_data  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_wr_ctrl.sv
// Scoreboard bench for fb_wr_ctrl with a small DEPTH so full sweeps stay short.
// Works with or without FB_RR_ARB_EN defined.
module tb_fb_wr_ctrl;

  localparam int AW = 11;
  localparam int DW = 1;
  localparam int DP = 1500;

  typedef struct {
    logic [AW-1:0] addr;
    logic          dat;
    bit            drop;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          wea;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          wr_drop;

  int  checks = 0;
  int  errors = 0;
  ev_t q[$];
  int  block;
  bit  pref;
  bit  acc0;
  bit  acc1;

  fb_wr_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .wea        (wea),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .wr_drop    (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic push_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.addr = a;
    e.dat  = d[0];
    e.drop = (int'(a) >= DP);
    q.push_back(e);
  endtask

  // One clock cycle; entered and left just after a falling edge.
  task automatic step();
    bit r0, r1, start, free;
    #1;
    start = clr_start;
    free  = (block == 0) && !start;
    r0 = 1'b0;
    r1 = 1'b0;
    if (free) begin
      if (req0_valid && req1_valid) begin
`ifdef FB_RR_ARB_EN
        if (pref) r1 = 1'b1; else r0 = 1'b1;
`else
        r0 = 1'b1;
`endif
      end else begin
        r0 = req0_valid;
        r1 = req1_valid;
      end
    end
    chk("req0_ready", 32'(req0_ready), 32'(r0));
    chk("req1_ready", 32'(req1_ready), 32'(r1));
    chk("clr_busy", 32'(clr_busy), 32'(block >= 2));
    chk("clr_done", 32'(clr_done), 32'(block == 1));
    @(posedge clk);
    if (r0) push_req(req0_addr, req0_data);
    if (r1) push_req(req1_addr, req1_data);
    if (r0 || r1) pref = r0;
    if (start && block <= 1) begin
      for (int i = 0; i < DP; i++) q.push_back('{AW'(i), 1'b0, 1'b0});
      block = DP + 1;
    end else if (block > 0) begin
      block--;
    end
    acc0 = r0;
    acc1 = r1;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DP + 20 && (req0_valid || req1_valid); i++) begin
      step();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    chk("drain_served", 32'(req0_valid || req1_valid), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wea", 32'(wea), 0);
    chk("rst_w_addr", 32'(w_addr), 0);
    chk("rst_w_data", 32'(w_data), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_clr_done", 32'(clr_done), 0);
    chk("rst_wr_drop", 32'(wr_drop), 0);
    q.delete();
    block = 0;
    pref  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return AW'($urandom_range(DP, (1 << AW) - 1));
    return AW'($urandom_range(0, DP - 1));
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (rst_n === 1'b1 && (wea === 1'b1 || wr_drop === 1'b1)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write at %0t: wea=%0d w_addr=%0d wr_drop=%0d, none expected",
                 $time, wea, w_addr, wr_drop);
      end else begin
        e = q.pop_front();
        chk("wr_drop", 32'(wr_drop), 32'(e.drop));
        chk("wea", 32'(wea), 32'(!e.drop));
        if (!e.drop) begin
          chk("w_addr", 32'(w_addr), 32'(e.addr));
          chk("w_data", 32'(w_data), 32'(e.dat));
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    clr_start  = 1'b0;
    req0_valid = 1'b0;
    req0_addr  = '0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_addr  = '0;
    req1_data  = '0;
    block      = 0;
    pref       = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_wea", 32'(wea), 0);
    chk("init_w_addr", 32'(w_addr), 0);
    chk("init_clr_busy", 32'(clr_busy), 0);
    chk("init_wr_drop", 32'(wr_drop), 0);
    rst_n = 1'b1;
    step();

    // single req0 write
    req0_valid = 1'b1; req0_addr = AW'(5); req0_data = 1'b1;
    drain();
    step();

    // both requesters held valid for four cycles
    req0_valid = 1'b1; req0_addr = AW'(100); req0_data = 1'b1;
    req1_valid = 1'b1; req1_addr = AW'(200); req1_data = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (acc0) req0_addr = req0_addr + AW'(1);
      if (acc1) req1_addr = req1_addr + AW'(1);
    end
    req0_valid = 1'b0;
    drain();

    // clear and req1 in the same cycle; req0 arrives mid-sweep
    clr_start = 1'b1;
    req1_valid = 1'b1; req1_addr = AW'(77); req1_data = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (10) step();
    req0_valid = 1'b1; req0_addr = AW'(1234); req0_data = 1'b1;
    drain();

    // out-of-range address is accepted but dropped
    req1_valid = 1'b1; req1_addr = AW'(DP); req1_data = 1'b1;
    drain();
    step();

    // reset in the middle of a sweep, then restart it
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (1000) step();
    chk("abort_point_addr", 32'(w_addr), 32'd1000);
    do_reset();
    repeat (4) step();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (DP + 3) step();

    // randomized traffic with occasional clears
    for (int c = 0; c < 4000; c++) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1; req0_addr = rand_addr(); req0_data = DW'($urandom_range(0, 1));
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1; req1_addr = rand_addr(); req1_data = DW'($urandom_range(0, 1));
      end
      clr_start = ($urandom_range(0, 1499) == 0);
      step();
      clr_start = 1'b0;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    drain();
    for (int i = 0; i < DP + 10 && block != 0; i++) step();
    repeat (3) step();
    chk("queue_empty", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
